param_ram_sp: RTL and testbench

Parametrised single-port synchronous RAM; successor to the fixed 32x16 distributed RAM in the memory-module family. Defaults to 256x16. Adds:
- registered read with selectable read-first/write-first behaviour;
- a built-in clear engine that zero-fills the array after reset or on request.

It sits between the datapath and the 256x16 memory module as the basic storage bank.

---
 rtl/param_ram_sp.sv | 91 +++++++++
 tb/tb_param_ram_sp.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_ram_sp.sv
// Single-port synchronous RAM with a registered read port and a zero-fill clear engine.
// 1-cycle read latency; while busy, writes and clr are dropped (not queued) and O holds 0.
module param_ram_sp #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 8,
    parameter bit WRITE_FIRST    = 1'b0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WEn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] D,
    input  logic              clr,
    output logic [DATA_W-1:0] O,
    output logic              busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;
    localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] o_q, o_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        o_d       = o_q;
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = D;
        case (state_q)
            IDLE: begin
                o_d = mem[addr];
                if (clr) begin
                    // clr wins over a same-cycle write; O drops to 0 with busy
                    state_d = CLEAR;
                    cnt_d   = '0;
                    o_d     = '0;
                end else if (WEn) begin
                    mem_we = 1'b1;
                    if (WRITE_FIRST) begin
                        o_d = D;
                    end
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q[ADDR_W-1:0];
                mem_wdata = '0;
                o_d       = '0;
                cnt_d     = cnt_q + (ADDR_W+1)'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            o_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
        end
    end

    // Array contents survive rst_n; only the clear engine zeroes them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign O    = o_q;
    assign busy = (state_q == CLEAR);

endmodule

// File: tb/tb_param_ram_sp.sv
// Bench for param_ram_sp: read-first and write-first 256x16 instances plus a 16x8 no-auto-clear instance,
// compared every cycle against a remaining-clear-count model, with literal checks of the key scenarios.
module tb_param_ram_sp;
    logic clk;
    logic rst_n = 1'b0;

    logic        a_wen = 1'b0, a_clr = 1'b0;
    logic [7:0]  a_addr = '0;
    logic [15:0] a_d = '0;
    logic [15:0] oa, ob;
    logic        busy_a, busy_b;

    logic        c_wen = 1'b0, c_clr = 1'b0;
    logic [3:0]  c_addr = '0;
    logic [7:0]  c_d = '0;
    logic [7:0]  oc;
    logic        busy_c;

    int n_chk = 0;
    int n_fail = 0;

    param_ram_sp #(.DATA_W(16), .ADDR_W(8), .WRITE_FIRST(1'b0), .CLEAR_ON_RESET(1'b1)) u_rf (
        .clk(clk), .rst_n(rst_n), .WEn(a_wen), .addr(a_addr), .D(a_d), .clr(a_clr),
        .O(oa), .busy(busy_a));

    param_ram_sp #(.DATA_W(16), .ADDR_W(8), .WRITE_FIRST(1'b1), .CLEAR_ON_RESET(1'b1)) u_wf (
        .clk(clk), .rst_n(rst_n), .WEn(a_wen), .addr(a_addr), .D(a_d), .clr(a_clr),
        .O(ob), .busy(busy_b));

    param_ram_sp #(.DATA_W(8), .ADDR_W(4), .WRITE_FIRST(1'b0), .CLEAR_ON_RESET(1'b0)) u_sw (
        .clk(clk), .rst_n(rst_n), .WEn(c_wen), .addr(c_addr), .D(c_d), .clr(c_clr),
        .O(oc), .busy(busy_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: a clear is just "N zero-writes still owed", nothing more.
    logic [15:0] ma [256];
    int          a_left = 0;
    logic [15:0] ea0 = '0, ea1 = '0;

    logic [7:0]  mc [16];
    bit          kc [16];
    int          c_left = 0;
    logic [7:0]  ec = '0;
    bit          ec_known = 1'b1;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            a_left = 256;
            ea0 = '0;
            ea1 = '0;
            c_left = 0;
            ec = '0;
            ec_known = 1'b1;
        end else begin
            if (a_left > 0) begin
                ma[256 - a_left] = '0;
                a_left--;
                ea0 = '0;
                ea1 = '0;
            end else if (a_clr) begin
                a_left = 256;
                ea0 = '0;
                ea1 = '0;
            end else begin
                ea0 = ma[a_addr];
                ea1 = a_wen ? a_d : ma[a_addr];
                if (a_wen) ma[a_addr] = a_d;
            end
            if (c_left > 0) begin
                mc[16 - c_left] = '0;
                kc[16 - c_left] = 1'b1;
                c_left--;
                ec = '0;
                ec_known = 1'b1;
            end else if (c_clr) begin
                c_left = 16;
                ec = '0;
                ec_known = 1'b1;
            end else begin
                ec = mc[c_addr];
                ec_known = kc[c_addr];
                if (c_wen) begin
                    mc[c_addr] = c_d;
                    kc[c_addr] = 1'b1;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        chk("o_read_first", 64'(oa), 64'(ea0));
        chk("o_write_first", 64'(ob), 64'(ea1));
        chk("busy_read_first", 64'(busy_a), 64'(a_left > 0));
        chk("busy_write_first", 64'(busy_b), 64'(a_left > 0));
        chk("busy_small", 64'(busy_c), 64'(c_left > 0));
        if (ec_known) chk("o_small", 64'(oc), 64'(ec));
    end

    // Counts edges until busy falls, driving junk that must be ignored meanwhile.
    task automatic run_clear(input bit on_c, input int exp_n, input string nm);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (on_c ? busy_c : busy_a) begin
                @(negedge clk);
                if (on_c) begin
                    c_wen = 1'($urandom); c_clr = 1'($urandom);
                    c_addr = 4'($urandom); c_d = 8'($urandom);
                end else begin
                    a_wen = 1'($urandom); a_clr = 1'($urandom);
                    a_addr = 8'($urandom); a_d = 16'($urandom);
                end
            end
        end while ((on_c ? busy_c : busy_a) && n < 2000);
        chk(nm, 64'(n), 64'(exp_n));
        @(negedge clk);
        if (on_c) begin
            c_wen = 1'b0; c_clr = 1'b0;
        end else begin
            a_wen = 1'b0; a_clr = 1'b0;
        end
    endtask

    logic [15:0] wv [5];
    logic [7:0]  cv;

    initial begin
        wv[0] = 16'h0000; wv[1] = 16'h0001; wv[2] = 16'h0010; wv[3] = 16'h0006; wv[4] = 16'h0012;

        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_busy_rf", 64'(busy_a), 64'd1);
        chk("rst_o_rf", 64'(oa), 64'd0);
        chk("rst_busy_small", 64'(busy_c), 64'd0);
        chk("rst_o_small", 64'(oc), 64'd0);
        rst_n = 1'b1;
        run_clear(1'b0, 256, "auto_clear_cycles");

        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            a_addr = 8'(i);
            @(posedge clk);
            #1;
            chk("cleared_word", 64'(oa), 64'h0);
        end

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_wen = 1'b1; a_addr = 8'(i); a_d = wv[i];
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_wen = 1'b0; a_addr = 8'(i);
            @(posedge clk);
            #1;
            chk("readback", 64'(oa), 64'(wv[i]));
        end

        @(negedge clk);
        a_wen = 1'b1; a_addr = 8'd7; a_d = 16'h1234;
        @(negedge clk);
        a_d = 16'hBEEF;
        @(posedge clk);
        #1;
        chk("rdw_read_first", 64'(oa), 64'h1234);
        chk("rdw_write_first", 64'(ob), 64'hBEEF);
        chk("model_rdw", 64'(ea0), 64'h1234);
        @(negedge clk);
        a_wen = 1'b0;
        @(posedge clk);
        #1;
        chk("rdw_next_read_first", 64'(oa), 64'hBEEF);

        @(negedge clk);
        a_wen = 1'b1; a_addr = 8'd9; a_d = 16'h5555;
        @(negedge clk);
        a_clr = 1'b1; a_d = 16'hAAAA;
        @(posedge clk);
        #1;
        chk("clr_busy_next", 64'(busy_a), 64'd1);
        chk("clr_o_zero", 64'(oa), 64'd0);
        run_clear(1'b0, 256, "clr_remaining_cycles");
        @(negedge clk);
        a_addr = 8'd9;
        @(posedge clk);
        #1;
        chk("collision_dropped", 64'(oa), 64'h0);

        @(negedge clk);
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        repeat (100) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midclr_rst_o", 64'(oa), 64'd0);
        chk("midclr_rst_busy", 64'(busy_a), 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_clear(1'b0, 256, "reclear_cycles");

        chk("small_idle_busy", 64'(busy_c), 64'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            c_wen = 1'b1; c_addr = 4'(i); c_d = 8'(i * 37 + 5);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            c_wen = 1'b0; c_addr = 4'(i);
            cv = 8'(i * 37 + 5);
            @(posedge clk);
            #1;
            chk("small_readback", 64'(oc), 64'(cv));
        end
        @(negedge clk);
        c_clr = 1'b1;
        run_clear(1'b1, 17, "small_clr_cycles");
        @(negedge clk);
        c_addr = 4'd5;
        @(posedge clk);
        #1;
        chk("small_cleared", 64'(oc), 64'h0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            a_wen = 1'($urandom); a_addr = 8'($urandom_range(0, 15)); a_d = 16'($urandom);
            a_clr = ($urandom_range(0, 999) == 0);
            c_wen = 1'($urandom); c_addr = 4'($urandom); c_d = 8'($urandom);
            c_clr = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        a_wen = 1'b0; a_clr = 1'b0; c_wen = 1'b0; c_clr = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
